// File: rtl/password_lock_controller.sv
// Four-digit password lock: checks entered codes against an external 4x4 store,
// supports password change while open, and locks out after repeated failures.
module password_lock_controller #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       relock,
  output logic [1:0] store_address,
  output logic       store_write,
  output logic [3:0] store_wdata,
  input  logic [3:0] store_rdata,
  output logic       digit_ready,
  output logic       unlocked,
  output logic       set_done,
  output logic       error,
  output logic       locked_out
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CHECK,
    OPEN,
    SET,
    LOCKOUT
  } state_t;

  localparam logic [3:0]  MAX_FAILS_L = 4'(MAX_FAILS);
  localparam logic [15:0] LOCK_LOAD   = 16'(LOCKOUT_CYCLES - 1);

  state_t      state;
  logic [1:0]  idx;
  logic [3:0]  fail_count;
  logic        mismatch;
  logic [15:0] lock_cnt;

  logic        accept;
  logic        code_bad;
  logic [3:0]  fail_inc;

  assign accept   = digit_valid & digit_ready;
  assign code_bad = mismatch | (digit != store_rdata);
  assign fail_inc = fail_count + 4'd1;

  // NOTE: every output gets a default before the case so no path leaves a latch.
  always_comb begin
    store_address = idx;
    store_write   = 1'b0;
    store_wdata   = 4'd0;
    digit_ready   = 1'b0;
    unlocked      = 1'b0;
    locked_out    = 1'b0;
    case (state)
      INIT: begin
        store_write = 1'b1;
      end
      IDLE, CHECK: begin
        digit_ready = 1'b1;
      end
      OPEN: begin
        digit_ready = 1'b1;
        unlocked    = 1'b1;
        // relock has priority over a new-password digit in the same cycle
        if (digit_valid && !relock) begin
          store_write = 1'b1;
          store_wdata = digit;
        end
      end
      SET: begin
        digit_ready = 1'b1;
        if (digit_valid) begin
          store_write = 1'b1;
          store_wdata = digit;
        end
      end
      LOCKOUT: begin
        locked_out = 1'b1;
      end
      default: begin
        store_write = 1'b0;
      end
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every branch sees
  // the pre-edge values of state, idx and the counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= INIT;
      idx        <= 2'd0;
      fail_count <= 4'd0;
      mismatch   <= 1'b0;
      lock_cnt   <= 16'd0;
      error      <= 1'b0;
      set_done   <= 1'b0;
    end else begin
      error    <= 1'b0;
      set_done <= 1'b0;
      case (state)
        INIT: begin
          if (idx == 2'd3) begin
            state <= IDLE;
            idx   <= 2'd0;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        IDLE, CHECK: begin
          if (accept) begin
            if (idx == 2'd3) begin
              idx      <= 2'd0;
              mismatch <= 1'b0;
              if (!code_bad) begin
                state      <= OPEN;
                fail_count <= 4'd0;
              end else if (fail_inc == MAX_FAILS_L) begin
                state      <= LOCKOUT;
                fail_count <= 4'd0;
                lock_cnt   <= LOCK_LOAD;
              end else begin
                state      <= IDLE;
                fail_count <= fail_inc;
                error      <= 1'b1;
              end
            end else begin
              state    <= CHECK;
              mismatch <= code_bad;
              idx      <= idx + 2'd1;
            end
          end
        end
        OPEN: begin
          if (relock) begin
            state <= IDLE;
            idx   <= 2'd0;
          end else if (digit_valid) begin
            state <= SET;
            idx   <= 2'd1;
          end
        end
        SET: begin
          if (digit_valid) begin
            if (idx == 2'd3) begin
              state    <= OPEN;
              idx      <= 2'd0;
              set_done <= 1'b1;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        LOCKOUT: begin
          if (lock_cnt == 16'd0) begin
            state <= IDLE;
            idx   <= 2'd0;
          end else begin
            lock_cnt <= lock_cnt - 16'd1;
          end
        end
        default: begin
          state <= INIT;
          idx   <= 2'd0;
        end
      endcase
    end
  end

endmodule
